multicycle_controller: RTL and testbench

- Moore-style FSM that sequences a shared-memory, multicycle RISC-V RV32I datapath.
- Fetch, decode, execute, memory and writeback each take their own cycle, reusing one ALU and one memory port.
- Drives the datapath mux selects, write enables and ALUOp; ALUOp feeds the existing alu_decoder.
- Adds a valid/ready memory handshake with a timeout watchdog.

---
 rtl/multicycle_controller.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM for a shared-memory, multicycle RV32I datapath.
// Fetch, decode, execute, memory and writeback each take their own cycle and
// reuse one ALU and one memory port. Memory accesses use a mem_req/mem_ready
// handshake guarded by a watchdog (MEM_TIMEOUT wait cycles, 0 = disabled).
//
// Build option:
//   ILLEGAL_TRAP_EN - when defined, an unknown opcode halts the FSM and sets
//                     the sticky illegal_instr output. When undefined, an
//                     unknown opcode retires as a NOP straight from DECODE.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       jalr,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
`ifdef ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic       bus_err
);

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Watchdog counter sized to hold MEM_TIMEOUT; saturates so a disabled
    // watchdog never wraps back through the compare value.
    localparam int              CNT_W     = (MEM_TIMEOUT < 32'sd2) ? 32'sd1
                                            : $clog2(MEM_TIMEOUT + 32'sd1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam bit               WDOG_EN   = (MEM_TIMEOUT != 32'sd0);

    typedef enum logic [3:0] {
        st_fetch    = 4'd0,
        st_decode   = 4'd1,
        st_memadr   = 4'd2,
        st_memread  = 4'd3,
        st_memwb    = 4'd4,
        st_memwrite = 4'd5,
        st_execr    = 4'd6,
        st_execi    = 4'd7,
        st_aluwb    = 4'd8,
        st_branch   = 4'd9,
        st_jal      = 4'd10,
        st_jalr     = 4'd11,
        st_jalrwb   = 4'd12,
        st_halt     = 4'd13
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             bus_err_r;
    logic             in_mem_s;
    logic             timeout_s;
    logic             op_known_s;
    logic             taken_s;

    // Memory-access states and watchdog expiry (mem_ready in the same cycle wins)
    always_comb begin
        in_mem_s  = (state_r == st_fetch) || (state_r == st_memread) ||
                    (state_r == st_memwrite);
        timeout_s = WDOG_EN && in_mem_s && !mem_ready && (wait_cnt_r == TIMEOUT_C);
    end

    // Opcode legality check used by DECODE
    always_comb begin
        op_known_s = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BR, OP_JAL, OP_JALR: op_known_s = 1'b1;
            default:                op_known_s = 1'b0;
        endcase
    end

    // Branch condition from funct3; unsupported encodings are never taken
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'b000:  taken_s = Zero;
            3'b001:  taken_s = !Zero;
            3'b100:  taken_s = ALUR31;
            3'b101:  taken_s = !ALUR31;
            default: taken_s = 1'b0;
        endcase
    end

    // Immediate format select, decoded straight from the opcode
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BR:    ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            st_fetch: begin
                if (mem_ready)      state_s = st_decode;
                else if (timeout_s) state_s = st_halt;
                else                state_s = st_fetch;
            end
            st_decode: begin
                case (op)
                    OP_LOAD, OP_STORE: state_s = st_memadr;
                    OP_RTYPE:          state_s = st_execr;
                    OP_ITYPE:          state_s = st_execi;
                    OP_BR:             state_s = st_branch;
                    OP_JAL:            state_s = st_jal;
                    OP_JALR:           state_s = st_jalr;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_s = st_halt;
`else
                    default:           state_s = st_fetch;
`endif
                endcase
            end
            st_memadr: begin
                if (op[5]) state_s = st_memwrite;
                else       state_s = st_memread;
            end
            st_memread: begin
                if (mem_ready)      state_s = st_memwb;
                else if (timeout_s) state_s = st_halt;
                else                state_s = st_memread;
            end
            st_memwrite: begin
                if (mem_ready)      state_s = st_fetch;
                else if (timeout_s) state_s = st_halt;
                else                state_s = st_memwrite;
            end
            st_memwb:  state_s = st_fetch;
            st_execr:  state_s = st_aluwb;
            st_execi:  state_s = st_aluwb;
            st_aluwb:  state_s = st_fetch;
            st_branch: state_s = st_fetch;
            st_jal:    state_s = st_aluwb;
            st_jalr:   state_s = st_jalrwb;
            st_jalrwb: state_s = st_fetch;
            st_halt:   state_s = st_halt;
            default:   state_s = st_fetch;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= st_fetch;
        else       state_r <= state_s;
    end

    // Watchdog counter: cleared on every state change, counts unanswered requests
    always_ff @(posedge clk) begin
        if (reset)                                            wait_cnt_r <= {CNT_W{1'b0}};
        else if (state_s != state_r)                          wait_cnt_r <= {CNT_W{1'b0}};
        else if (in_mem_s && !mem_ready && wait_cnt_r != CNT_MAX) wait_cnt_r <= wait_cnt_r + CNT_ONE;
        else                                                  wait_cnt_r <= wait_cnt_r;
    end

    // Sticky bus error flag
    always_ff @(posedge clk) begin
        if (reset)          bus_err_r <= 1'b0;
        else if (timeout_s) bus_err_r <= 1'b1;
        else                bus_err_r <= bus_err_r;
    end

    assign bus_err = bus_err_r;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal-opcode flag raised from DECODE
    always_ff @(posedge clk) begin
        if (reset)                                     illegal_r <= 1'b0;
        else if (state_r == st_decode && !op_known_s)  illegal_r <= 1'b1;
        else                                           illegal_r <= illegal_r;
    end

    assign illegal_instr = illegal_r;
`endif

    // Per-state datapath controls; reset forces enables low with FETCH selects
    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        jalr       = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ResultSrc  = 2'b00;
        instr_done = 1'b0;
        if (reset) begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (state_r)
                st_fetch: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                st_decode: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b01;
`ifdef ILLEGAL_TRAP_EN
                    instr_done = 1'b0;
`else
                    instr_done = !op_known_s;
`endif
                end
                st_memadr: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                st_memread: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                st_memwb: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                st_memwrite: begin
                    mem_req    = 1'b1;
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                st_execr: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b00;
                    ALUOp   = 2'b10;
                end
                st_execi: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                st_aluwb: begin
                    ResultSrc  = 2'b00;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                st_branch: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b00;
                    ALUOp      = 2'b01;
                    ResultSrc  = 2'b00;
                    PCWrite    = taken_s;
                    instr_done = 1'b1;
                end
                st_jal: begin
                    // PC takes the target held in ALUOut; ALU forms OldPC+4
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b00;
                    PCWrite   = 1'b1;
                end
                st_jalr: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    jalr      = 1'b1;
                end
                st_jalrwb: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    ResultSrc  = 2'b10;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                st_halt: begin
                    mem_req = 1'b0;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_controller (MEM_TIMEOUT = 4).
// Each instruction is expanded into the list of cycles it must take, with the
// control word each cycle must show, and the DUT is compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       Zero = 1'b0;
    logic       ALUR31 = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, jalr;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
    logic       instr_done, bus_err;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int n_total = 0;
    int n_pass  = 0;

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
        .ALUR31(ALUR31), .mem_ready(mem_ready), .mem_req(mem_req),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .jalr(jalr),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .instr_done(instr_done),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr),
`endif
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [15:0] obs_vec;
    assign obs_vec = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, jalr,
                      ALUSrcA, ALUSrcB, ALUOp, ResultSrc, instr_done};

    typedef struct {
        string name;
        bit    is_mem;
        bit    rdy;
    } step_t;

    // Control word each instruction step must show
    function automatic logic [15:0] exp_vec(input string st, input bit rdy, input bit tk);
        logic mreq = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, pcw = 1'b0;
        logic rw = 1'b0, jr = 1'b0, done = 1'b0;
        logic [1:0] a = 2'b00, b = 2'b00, aop = 2'b00, rs = 2'b00;
        if (st == "fetch") begin
            mreq = 1'b1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy;
        end else if (st == "decode") begin
            a = 2'b01; b = 2'b01;
        end else if (st == "decode_nop") begin
            a = 2'b01; b = 2'b01; done = 1'b1;
        end else if (st == "memadr") begin
            a = 2'b10; b = 2'b01;
        end else if (st == "memread") begin
            mreq = 1'b1; adr = 1'b1;
        end else if (st == "memwb") begin
            rs = 2'b01; rw = 1'b1; done = 1'b1;
        end else if (st == "memwrite") begin
            mreq = 1'b1; adr = 1'b1; mw = 1'b1; done = rdy;
        end else if (st == "execr") begin
            a = 2'b10; aop = 2'b10;
        end else if (st == "execi") begin
            a = 2'b10; b = 2'b01; aop = 2'b10;
        end else if (st == "aluwb") begin
            rw = 1'b1; done = 1'b1;
        end else if (st == "branch") begin
            a = 2'b10; aop = 2'b01; done = 1'b1; pcw = tk;
        end else if (st == "jal") begin
            a = 2'b01; b = 2'b10; pcw = 1'b1;
        end else if (st == "jalr") begin
            a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1'b1; jr = 1'b1;
        end else if (st == "jalrwb") begin
            a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1'b1; done = 1'b1;
        end else if (st == "reset") begin
            b = 2'b10; rs = 2'b10;
        end else begin
            mreq = 1'b0; // halt: everything low
        end
        return {mreq, adr, mw, irw, pcw, rw, jr, a, b, aop, rs, done};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011)      return 2'b01;
        else if (o == 7'b1100011) return 2'b10;
        else if (o == 7'b1101111) return 2'b11;
        else                      return 2'b00;
    endfunction

    function automatic bit br_taken(input logic [2:0] f, input bit z, input bit r);
        if (f == 3'd0)      return z;
        else if (f == 3'd1) return !z;
        else if (f == 3'd4) return r;
        else if (f == 3'd5) return !r;
        else                return 1'b0;
    endfunction

    // One cycle: drive inputs at the negedge, compare, advance to next negedge
    task automatic do_step(input step_t s, input bit force_zr, input bit zv, input bit rv,
                           input bit exp_berr, output bit done_seen);
        logic [15:0] e;
        mem_ready = s.is_mem ? s.rdy : 1'($urandom_range(0, 1));
        Zero      = force_zr ? zv : 1'($urandom_range(0, 1));
        ALUR31    = force_zr ? rv : 1'($urandom_range(0, 1));
        #1;
        e = exp_vec(s.name, mem_ready, br_taken(funct3, Zero, ALUR31));
        n_total++;
        if (obs_vec !== e) $display("FAIL ctrl[%s] op=%b f3=%b got %h want %h",
                                    s.name, op, funct3, obs_vec, e);
        else n_pass++;
        n_total++;
        if (ImmSrc !== exp_imm(op)) $display("FAIL immsrc op=%b got %b want %b",
                                             op, ImmSrc, exp_imm(op));
        else n_pass++;
        n_total++;
        if (bus_err !== exp_berr) $display("FAIL bus_err[%s] got %b want %b",
                                           s.name, bus_err, exp_berr);
        else n_pass++;
        done_seen = instr_done;
        @(negedge clk);
    endtask

    // Expand one instruction into its cycles, run it, and return its length
    task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3_i, input int fw,
                             input int mw, input bit force_zr, input bit zv, input bit rv,
                             output int cycles);
        step_t q[$];
        bit    d;
        int    first_done = -1;
        for (int i = 0; i < fw; i++) q.push_back('{"fetch", 1'b1, 1'b0});
        q.push_back('{"fetch", 1'b1, 1'b1});
        case (op_i)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111: q.push_back('{"decode", 1'b0, 1'b0});
            default:                            q.push_back('{"decode_nop", 1'b0, 1'b0});
        endcase
        case (op_i)
            7'b0000011: begin
                q.push_back('{"memadr", 1'b0, 1'b0});
                for (int i = 0; i < mw; i++) q.push_back('{"memread", 1'b1, 1'b0});
                q.push_back('{"memread", 1'b1, 1'b1});
                q.push_back('{"memwb", 1'b0, 1'b0});
            end
            7'b0100011: begin
                q.push_back('{"memadr", 1'b0, 1'b0});
                for (int i = 0; i < mw; i++) q.push_back('{"memwrite", 1'b1, 1'b0});
                q.push_back('{"memwrite", 1'b1, 1'b1});
            end
            7'b0110011: begin q.push_back('{"execr", 1'b0, 1'b0}); q.push_back('{"aluwb", 1'b0, 1'b0}); end
            7'b0010011: begin q.push_back('{"execi", 1'b0, 1'b0}); q.push_back('{"aluwb", 1'b0, 1'b0}); end
            7'b1100011: q.push_back('{"branch", 1'b0, 1'b0});
            7'b1101111: begin q.push_back('{"jal", 1'b0, 1'b0}); q.push_back('{"aluwb", 1'b0, 1'b0}); end
            7'b1100111: begin q.push_back('{"jalr", 1'b0, 1'b0}); q.push_back('{"jalrwb", 1'b0, 1'b0}); end
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            if (i == fw + 1) begin
                op = op_i;
                funct3 = f3_i;
            end
            do_step(q[i], force_zr, zv, rv, 1'b0, d);
            if (d && first_done < 0) first_done = i;
        end
        cycles = first_done + 1;
        n_total++;
        if (cycles !== q.size()) $display("FAIL cpi op=%b got %0d want %0d", op_i, cycles, q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            Zero = 1'($urandom_range(0, 1));
            #1;
            n_total++;
            if (obs_vec !== exp_vec("reset", 1'b0, 1'b0))
                $display("FAIL reset_ctrl got %h want %h", obs_vec, exp_vec("reset", 1'b0, 1'b0));
            else n_pass++;
            n_total++;
            if (bus_err !== 1'b0) $display("FAIL reset_bus_err got %b want 0", bus_err);
            else n_pass++;
`ifdef ILLEGAL_TRAP_EN
            n_total++;
            if (illegal_instr !== 1'b0) $display("FAIL reset_illegal got %b want 0", illegal_instr);
            else n_pass++;
`endif
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic expect_cycles(input string nm, input int got, input int want);
        n_total++;
        if (got !== want) $display("FAIL %s_cycles got %0d want %0d", nm, got, want);
        else n_pass++;
    endtask

    task automatic test_rtype();
        int c;
        run_instr(7'b0110011, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, c);   // add x3,x1,x2
        expect_cycles("add", c, 4);
        run_instr(7'b0010011, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, c);   // addi
        expect_cycles("addi", c, 4);
    endtask

    task automatic test_load_store();
        int c;
        run_instr(7'b0000011, 3'b010, 0, 3, 1'b0, 1'b0, 1'b0, c);   // lw, 3 waits
        expect_cycles("lw_wait3", c, 8);
        run_instr(7'b0000011, 3'b010, 0, 0, 1'b0, 1'b0, 1'b0, c);
        expect_cycles("lw", c, 5);
        run_instr(7'b0100011, 3'b010, 0, 0, 1'b0, 1'b0, 1'b0, c);
        expect_cycles("sw", c, 4);
        run_instr(7'b0100011, 3'b010, TO, TO, 1'b0, 1'b0, 1'b0, c); // longest legal waits
        expect_cycles("sw_maxwait", c, 4 + 2 * TO);
    endtask

    task automatic test_branch();
        int c;
        run_instr(7'b1100011, 3'b000, 0, 0, 1'b1, 1'b1, 1'b0, c);   // beq, Zero=1: taken
        expect_cycles("beq", c, 3);
        run_instr(7'b1100011, 3'b001, 0, 0, 1'b1, 1'b1, 1'b0, c);   // bne, Zero=1: not taken
        run_instr(7'b1100011, 3'b100, 0, 0, 1'b1, 1'b0, 1'b1, c);   // blt, ALUR31=1: taken
        run_instr(7'b1100011, 3'b101, 0, 0, 1'b1, 1'b0, 1'b1, c);   // bge, ALUR31=1: not taken
        run_instr(7'b1100011, 3'b010, 0, 0, 1'b1, 1'b1, 1'b1, c);   // reserved funct3
    endtask

    task automatic test_jumps();
        int c;
        run_instr(7'b1100111, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, c);
        expect_cycles("jalr", c, 4);
        run_instr(7'b1101111, 3'b000, 1, 0, 1'b0, 1'b0, 1'b0, c);
        expect_cycles("jal_fw1", c, 5);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111};
        int c;
        for (int k = 0; k < 60; k++) begin
            run_instr(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                      $urandom_range(0, TO), $urandom_range(0, TO), 1'b0, 1'b0, 1'b0, c);
        end
    endtask

    task automatic test_unknown_op();
`ifdef ILLEGAL_TRAP_EN
        bit d;
        do_step('{"fetch", 1'b1, 1'b1}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        op = 7'b0000000;
        do_step('{"decode", 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (illegal_instr !== 1'b1) $display("FAIL illegal_set got %b want 1", illegal_instr);
            else n_pass++;
            do_step('{"halt", 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (illegal_instr !== 1'b0) $display("FAIL illegal_clear got %b want 0", illegal_instr);
        else n_pass++;
        reset = 1'b0;
        op = 7'b0110011;
`else
        int c;
        run_instr(7'b0000000, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, c);
        expect_cycles("nop", c, 2);
        run_instr(7'b1111111, 3'b000, 2, 0, 1'b0, 1'b0, 1'b0, c);
        expect_cycles("nop_fw2", c, 4);
`endif
    endtask

    task automatic test_timeout();
        bit d;
        int c;
        for (int i = 0; i <= TO; i++) do_step('{"fetch", 1'b1, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        for (int i = 0; i < 3; i++) do_step('{"halt", 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b1, d);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (bus_err !== 1'b0) $display("FAIL bus_err_clear got %b want 0", bus_err);
        else n_pass++;
        reset = 1'b0;
        run_instr(7'b0110011, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, c);
        // Timeout while waiting on a load
        for (int i = 0; i < 1; i++) do_step('{"fetch", 1'b1, 1'b1}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        op = 7'b0000011;
        do_step('{"decode", 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        do_step('{"memadr", 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        for (int i = 0; i <= TO; i++) do_step('{"memread", 1'b1, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, d);
        do_step('{"halt", 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_unknown_op();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
